// File: rtl/input_spike_encoder_pkg.sv
// Shared types and width helpers for the spike encoder front stage.
package input_spike_encoder_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ENCODE    = 2'd1,
    WAIT_CONV = 2'd2,
    DONE      = 2'd3
  } enc_state_t;

  localparam int PIXEL_W_DEF = 8;

  typedef logic [PIXEL_W_DEF-1:0] pixel_t;

  // Address width for a buffer of n entries; never narrower than one bit.
  function automatic int addr_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/input_spike_encoder_if.sv
// Pixel-read, spike-write and conv_1_1 handshake bundle.
interface input_spike_encoder_if
  import input_spike_encoder_pkg::*;
#(
  parameter int ADDR_W  = addr_width(32 * 32),
  parameter int CH      = 3,
  parameter int PIXEL_W = PIXEL_W_DEF,
  parameter int TS_W    = 2
);
  logic [ADDR_W-1:0]     pix_rd_addr;
  logic [CH*PIXEL_W-1:0] pix_rd_data;
  logic                  spike_wr_en;
  logic [ADDR_W-1:0]     spike_wr_addr;
  logic [CH-1:0]         spike_wr_data;
  logic [TS_W-1:0]       timestep;
  logic                  spikes_avail;
  logic                  conv_done;

  modport master (
    output pix_rd_addr, spike_wr_en, spike_wr_addr, spike_wr_data, timestep, spikes_avail,
    input  pix_rd_data, conv_done
  );

  modport slave (
    input  pix_rd_addr, spike_wr_en, spike_wr_addr, spike_wr_data, timestep, spikes_avail,
    output pix_rd_data, conv_done
  );
endinterface

// File: rtl/input_spike_encoder_enc_mem_ram.sv
// Membrane-potential store: simple dual-port RAM, registered read (1-cycle latency).
module enc_mem_ram
  import input_spike_encoder_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 27,
  localparam int AW   = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Write port and registered read port.
  // NOTE: storage has no reset so it maps onto block RAM; stale contents are
  // harmless because timestep 0 ignores whatever is read back.
  // NOTE: non-blocking assignments keep read-before-write ordering well defined.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[wr_addr_i] <= wr_data_i;
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;
endmodule

// File: rtl/input_spike_encoder.sv
// Integrate-and-fire rate encoder: turns one stored RGB frame into TIME_STEPS
// binary spike frames and hands each one to conv_1_1.
module input_spike_encoder
  import input_spike_encoder_pkg::*;
#(
  parameter int TIME_STEPS        = 2,
  parameter int INPUT_CHANNELS    = 3,
  parameter int INPUT_FRAME_WIDTH = 32,
  parameter int PIXEL_W           = 8,
  parameter int THRESHOLD         = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic input_avail,
  output logic busy,
  output logic enc_done,
  input_spike_encoder_if.master bus
);
  localparam int FRAME_SIZE = INPUT_FRAME_WIDTH * INPUT_FRAME_WIDTH;
  localparam int ADDR_W     = addr_width(FRAME_SIZE);
  localparam int TS_W       = $clog2(TIME_STEPS) + 1;
  localparam int MW         = PIXEL_W + 1;
  localparam int CNT_W      = ADDR_W + 1;
  localparam logic [MW-1:0]     THR       = MW'(THRESHOLD);
  localparam logic [MW-1:0]     THR_M1    = MW'(THRESHOLD - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_SIZE - 1);
  localparam logic [TS_W-1:0]   LAST_TS   = TS_W'(TIME_STEPS - 1);
  localparam logic [CNT_W-1:0]  FRAME_CNT = CNT_W'(FRAME_SIZE);

  enc_state_t state_q, state_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic avail_q, start, issue, spikes_avail;
  logic [CNT_W-1:0] cnt_q;
  logic [ADDR_W-1:0] rd_addr, a1_q, a2_q;
  logic v1_q, v2_q, fin_q;
  logic [INPUT_CHANNELS-1:0] spk_d, spk_q;
  logic [INPUT_CHANNELS*MW-1:0] res_d, res_q, mem_rd_data;

  assign start   = input_avail & ~avail_q;
  assign issue   = (state_q == ENCODE) && (cnt_q < FRAME_CNT);
  assign rd_addr = issue ? cnt_q[ADDR_W-1:0] : '0;

  // State, timestep and input_avail edge-detector registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ts_q    <= '0;
      avail_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_d;
      avail_q <= input_avail;
    end
  end

  // Next-state and status decode.
  // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    ts_d         = ts_q;
    busy         = 1'b1;
    enc_done     = 1'b0;
    spikes_avail = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        ts_d = '0;
        if (start) state_d = ENCODE;
      end
      ENCODE: begin
        if (fin_q) begin
          spikes_avail = 1'b1;
          state_d      = WAIT_CONV;
        end
      end
      WAIT_CONV: begin
        if (bus.conv_done) begin
          if (ts_q < LAST_TS) begin
            ts_d    = ts_q + TS_W'(1);
            state_d = ENCODE;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        enc_done = 1'b1;
        ts_d     = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Integrate-and-fire arithmetic, one copy per channel; result lands in stage 2.
  for (genvar c = 0; c < INPUT_CHANNELS; c++) begin : g_ch
    logic [MW-1:0] pix_c, mem_c, m_c, sub_c;
    logic          spk_c;
    assign pix_c = MW'(bus.pix_rd_data[c*PIXEL_W +: PIXEL_W]);
    // Timestep 0 starts from rest, so the RAM never needs clearing between images.
    assign mem_c = (ts_q == '0) ? '0 : mem_rd_data[c*MW +: MW];
    assign m_c   = mem_c + pix_c;
    assign spk_c = (m_c >= THR);
    assign sub_c = spk_c ? (m_c - THR) : m_c;
    assign spk_d[c]           = spk_c;
    assign res_d[c*MW +: MW]  = (sub_c > THR_M1) ? THR_M1 : sub_c;
  end

  // Address counter and two-stage valid/address pipeline (issue -> data -> write).
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      v1_q  <= 1'b0;
      a1_q  <= '0;
      v2_q  <= 1'b0;
      a2_q  <= '0;
      spk_q <= '0;
      res_q <= '0;
      fin_q <= 1'b0;
    end else begin
      if (issue)                 cnt_q <= cnt_q + CNT_W'(1);
      else if (state_q != ENCODE) cnt_q <= '0;
      v1_q  <= issue;
      a1_q  <= rd_addr;
      v2_q  <= v1_q;
      a2_q  <= v1_q ? a1_q : '0;
      spk_q <= v1_q ? spk_d : '0;
      res_q <= res_d;
      fin_q <= v2_q && (a2_q == LAST_ADDR);
    end
  end

  // Read address k and write address k-2 never collide within a step.
  enc_mem_ram #(
    .DEPTH (FRAME_SIZE),
    .WIDTH (INPUT_CHANNELS * MW)
  ) u_mem (
    .clk       (clk),
    .we_i      (v2_q),
    .wr_addr_i (a2_q),
    .wr_data_i (res_q),
    .rd_addr_i (rd_addr),
    .rd_data_o (mem_rd_data)
  );

  assign bus.pix_rd_addr   = rd_addr;
  assign bus.spike_wr_en   = v2_q;
  assign bus.spike_wr_addr = a2_q;
  assign bus.spike_wr_data = spk_q;
  assign bus.timestep      = ts_q;
  assign bus.spikes_avail  = spikes_avail;
endmodule

// File: tb/tb_input_spike_encoder.sv
// Directed bench for input_spike_encoder: pixel memory model, conv_1_1 responder, monitor.
module tb_input_spike_encoder;
  import input_spike_encoder_pkg::*;

  localparam int FS = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic input_avail = 1'b0;
  logic busy, enc_done;

  input_spike_encoder_if #(.ADDR_W(10), .CH(3), .PIXEL_W(8), .TS_W(2)) bus ();

  input_spike_encoder #(
    .TIME_STEPS(2), .INPUT_CHANNELS(3), .INPUT_FRAME_WIDTH(32), .PIXEL_W(8), .THRESHOLD(256)
  ) dut (
    .clk(clk), .rst(rst), .input_avail(input_avail), .busy(busy), .enc_done(enc_done), .bus(bus)
  );

  always #5 clk = ~clk;

  // Pixel memory with one-cycle registered read.
  logic [23:0] pixmem [FS];
  always @(posedge clk) bus.pix_rd_data <= pixmem[bus.pix_rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: accumulates DUT activity, sampled on the falling edge.
  int wr_total = 0, nz_total = 0, sa_total = 0, ed_total = 0, ed_cyc = 0;
  int burst_start [2];
  int last_wr [2];
  int sa_cyc [2];
  logic prev_wr = 1'b0;
  logic [2:0] spk [2][FS];
  always @(negedge clk) begin
    if (bus.spike_wr_en) begin
      wr_total <= wr_total + 1;
      if (bus.spike_wr_data != 3'b000) nz_total <= nz_total + 1;
      spk[bus.timestep[0]][bus.spike_wr_addr] <= bus.spike_wr_data;
      if (!prev_wr) burst_start[bus.timestep[0]] <= cyc;
      last_wr[bus.timestep[0]] <= cyc;
    end
    prev_wr <= bus.spike_wr_en;
    if (bus.spikes_avail) begin
      sa_total <= sa_total + 1;
      sa_cyc[bus.timestep[0]] <= cyc;
    end
    if (enc_done) begin
      ed_total <= ed_total + 1;
      ed_cyc   <= cyc;
    end
  end

  int n_checks = 0, n_fail = 0;
  int t_start = 0;
  int cd_cyc [2];

  function automatic logic [23:0] px(input pixel_t c0, input pixel_t c1, input pixel_t c2);
    return {c2, c1, c0};
  endfunction

  task automatic load_zero();
    for (int i = 0; i < FS; i++) pixmem[i] = 24'h0;
  endtask

  task automatic load_basic();
    load_zero();
    pixmem[0]    = px(8'd128, 8'd128, 8'd128);
    pixmem[1]    = px(8'd127, 8'd127, 8'd127);
    pixmem[5]    = px(8'd128, 8'd255, 8'd0);
    pixmem[7]    = px(8'd200, 8'd100, 8'd60);
    pixmem[9]    = px(8'd255, 8'd255, 8'd255);
    pixmem[1023] = px(8'd1, 8'd1, 8'd255);
  endtask

  task automatic start_image();
    @(negedge clk);
    input_avail = 1'b1;
    t_start = cyc;
    @(negedge clk);
    input_avail = 1'b0;
  endtask

  task automatic wait_sa(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.spikes_avail) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pulse_conv(input int delay, input int s);
    repeat (delay) @(negedge clk);
    bus.conv_done = 1'b1;
    cd_cyc[s] = cyc;
    @(negedge clk);
    bus.conv_done = 1'b0;
  endtask

  task automatic wait_ed(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (enc_done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic run_image(input int delay, output bit ok);
    bit o;
    ok = 1'b1;
    start_image();
    for (int s = 0; s < 2; s++) begin
      wait_sa(o);
      if (!o) begin ok = 1'b0; return; end
      pulse_conv(delay, s);
    end
    wait_ed(o);
    if (!o) ok = 1'b0;
  endtask

  task automatic test_reset();
    logic [28:0] v;
    repeat (3) @(negedge clk);
    v = {busy, enc_done, bus.spike_wr_en, bus.spikes_avail, bus.timestep,
         bus.pix_rd_addr, bus.spike_wr_addr, bus.spike_wr_data};
    n_checks++;
    if (v !== 29'h0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0", v); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    int   addrs [6] = '{0, 1, 5, 7, 9, 1023};
    logic [2:0] e1 [6] = '{3'b111, 3'b000, 3'b011, 3'b001, 3'b111, 3'b100};
    int w0, n0, s0, e0;
    bit ok;
    load_basic();
    w0 = wr_total; n0 = nz_total; s0 = sa_total; e0 = ed_total;
    run_image(5, ok);
    repeat (2) @(negedge clk);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_complete got=%b exp=1", ok); end
    n_checks++;
    if (wr_total - w0 !== 2 * FS) begin n_fail++; $display("FAIL basic_writes got=%0d exp=%0d", wr_total - w0, 2 * FS); end
    n_checks++;
    if (nz_total - n0 !== 5) begin n_fail++; $display("FAIL basic_nonzero got=%0d exp=5", nz_total - n0); end
    n_checks++;
    if (sa_total - s0 !== 2 || ed_total - e0 !== 1) begin
      n_fail++; $display("FAIL basic_pulses sa=%0d ed=%0d exp sa=2 ed=1", sa_total - s0, ed_total - e0);
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (spk[0][addrs[i]] !== 3'b000) begin
        n_fail++; $display("FAIL basic_t0 addr=%0d got=%b exp=000", addrs[i], spk[0][addrs[i]]);
      end
      n_checks++;
      if (spk[1][addrs[i]] !== e1[i]) begin
        n_fail++; $display("FAIL basic_t1 addr=%0d got=%b exp=%b", addrs[i], spk[1][addrs[i]], e1[i]);
      end
    end
  endtask

  task automatic test_zero_frame();
    int w0, n0, s0, e0;
    bit ok;
    load_zero();
    w0 = wr_total; n0 = nz_total; s0 = sa_total; e0 = ed_total;
    run_image(3, ok);
    repeat (2) @(negedge clk);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL zero_complete got=%b exp=1", ok); end
    n_checks++;
    if (wr_total - w0 !== 2 * FS) begin n_fail++; $display("FAIL zero_writes got=%0d exp=%0d", wr_total - w0, 2 * FS); end
    n_checks++;
    if (nz_total - n0 !== 0) begin n_fail++; $display("FAIL zero_nonzero got=%0d exp=0", nz_total - n0); end
    n_checks++;
    if (sa_total - s0 !== 2) begin n_fail++; $display("FAIL zero_spikes_avail got=%0d exp=2", sa_total - s0); end
    n_checks++;
    if (ed_total - e0 !== 1) begin n_fail++; $display("FAIL zero_enc_done got=%0d exp=1", ed_total - e0); end
  endtask

  task automatic test_timing();
    int w0;
    bit ok;
    load_basic();
    w0 = wr_total;
    run_image(50, ok);
    repeat (2) @(negedge clk);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL timing_complete got=%b exp=1", ok); end
    n_checks++;
    if (burst_start[0] !== t_start + 3) begin n_fail++; $display("FAIL timing_first_wr got=%0d exp=%0d", burst_start[0], t_start + 3); end
    n_checks++;
    if (last_wr[0] !== t_start + FS + 2) begin n_fail++; $display("FAIL timing_last_wr got=%0d exp=%0d", last_wr[0], t_start + FS + 2); end
    n_checks++;
    if (sa_cyc[0] !== t_start + FS + 3) begin n_fail++; $display("FAIL timing_sa0 got=%0d exp=%0d", sa_cyc[0], t_start + FS + 3); end
    n_checks++;
    if (burst_start[1] !== cd_cyc[0] + 3) begin n_fail++; $display("FAIL timing_t1_start got=%0d exp=%0d", burst_start[1], cd_cyc[0] + 3); end
    n_checks++;
    if (sa_cyc[1] !== cd_cyc[0] + FS + 3) begin n_fail++; $display("FAIL timing_sa1 got=%0d exp=%0d", sa_cyc[1], cd_cyc[0] + FS + 3); end
    n_checks++;
    if (ed_cyc !== cd_cyc[1] + 1) begin n_fail++; $display("FAIL timing_enc_done got=%0d exp=%0d", ed_cyc, cd_cyc[1] + 1); end
    n_checks++;
    if (wr_total - w0 !== 2 * FS) begin n_fail++; $display("FAIL timing_writes got=%0d exp=%0d", wr_total - w0, 2 * FS); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL timing_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_second_image();
    bit ok_a, ok_b;
    load_zero();
    pixmem[5] = px(8'd255, 8'd255, 8'd255);
    run_image(2, ok_a);
    pixmem[5] = px(8'd128, 8'd128, 8'd128);
    run_image(2, ok_b);
    repeat (2) @(negedge clk);
    n_checks++;
    if (ok_a !== 1'b1 || ok_b !== 1'b1) begin n_fail++; $display("FAIL second_complete got=%b%b exp=11", ok_a, ok_b); end
    n_checks++;
    if (spk[0][5] !== 3'b000) begin n_fail++; $display("FAIL second_t0 got=%b exp=000", spk[0][5]); end
    n_checks++;
    if (spk[1][5] !== 3'b111) begin n_fail++; $display("FAIL second_t1 got=%b exp=111", spk[1][5]); end
  endtask

  task automatic test_ignored_inputs();
    int w0, s0, e0, w_mid;
    bit ok;
    load_basic();
    w0 = wr_total; s0 = sa_total; e0 = ed_total;
    @(negedge clk);
    input_avail = 1'b1;
    t_start = cyc;
    repeat (20) @(negedge clk);
    input_avail = 1'b0;
    repeat (150) @(negedge clk);
    input_avail = 1'b1;
    @(negedge clk);
    input_avail = 1'b0;
    repeat (100) @(negedge clk);
    bus.conv_done = 1'b1;
    @(negedge clk);
    bus.conv_done = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || bus.timestep !== 2'd0) begin
      n_fail++; $display("FAIL ignore_mid_encode busy=%b ts=%0d exp busy=1 ts=0", busy, bus.timestep);
    end
    wait_sa(ok);
    w_mid = wr_total;
    bus.conv_done = 1'b1;
    @(negedge clk);
    bus.conv_done = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL ignore_sa0 got=%b exp=1", ok); end
    n_checks++;
    if (bus.timestep !== 2'd0 || busy !== 1'b1 || wr_total !== w_mid) begin
      n_fail++; $display("FAIL ignore_same_cycle_conv ts=%0d busy=%b writes=%0d exp ts=0 busy=1 writes=0",
                         bus.timestep, busy, wr_total - w_mid);
    end
    pulse_conv(1, 0);
    wait_sa(ok);
    pulse_conv(3, 1);
    wait_ed(ok);
    repeat (3) @(negedge clk);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL ignore_complete got=%b exp=1", ok); end
    n_checks++;
    if (wr_total - w0 !== 2 * FS || sa_total - s0 !== 2 || ed_total - e0 !== 1) begin
      n_fail++; $display("FAIL ignore_counts writes=%0d sa=%0d ed=%0d exp 2048/2/1",
                         wr_total - w0, sa_total - s0, ed_total - e0);
    end
    n_checks++;
    if (sa_cyc[0] !== t_start + FS + 3) begin n_fail++; $display("FAIL ignore_sa0_cycle got=%0d exp=%0d", sa_cyc[0], t_start + FS + 3); end
    n_checks++;
    if (spk[1][5] !== 3'b011 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ignore_result spk=%b busy=%b exp spk=011 busy=0", spk[1][5], busy);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [28:0] v;
    int w0, s0, e0;
    bit ok;
    load_basic();
    start_image();
    wait_sa(ok);
    pulse_conv(2, 0);
    repeat (100) @(negedge clk);
    n_checks++;
    if (ok !== 1'b1 || busy !== 1'b1 || bus.timestep !== 2'd1) begin
      n_fail++; $display("FAIL rstmid_in_t1 ok=%b busy=%b ts=%0d exp 1/1/1", ok, busy, bus.timestep);
    end
    rst = 1'b1;
    @(negedge clk);
    v = {busy, enc_done, bus.spike_wr_en, bus.spikes_avail, bus.timestep,
         bus.pix_rd_addr, bus.spike_wr_addr, bus.spike_wr_data};
    rst = 1'b0;
    n_checks++;
    if (v !== 29'h0) begin n_fail++; $display("FAIL rstmid_outputs got=%h exp=0", v); end
    w0 = wr_total; s0 = sa_total; e0 = ed_total;
    repeat (1100) @(negedge clk);
    n_checks++;
    if (wr_total !== w0 || sa_total !== s0 || ed_total !== e0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_quiet writes=%0d sa=%0d ed=%0d busy=%b exp all 0",
                         wr_total - w0, sa_total - s0, ed_total - e0, busy);
    end
    run_image(4, ok);
    repeat (2) @(negedge clk);
    n_checks++;
    if (ok !== 1'b1 || wr_total - w0 !== 2 * FS) begin
      n_fail++; $display("FAIL rstmid_restart ok=%b writes=%0d exp 1/%0d", ok, wr_total - w0, 2 * FS);
    end
    n_checks++;
    if (spk[0][5] !== 3'b000 || spk[1][5] !== 3'b011) begin
      n_fail++; $display("FAIL rstmid_addr5 t0=%b t1=%b exp 000/011", spk[0][5], spk[1][5]);
    end
    n_checks++;
    if (spk[1][0] !== 3'b111) begin n_fail++; $display("FAIL rstmid_addr0 got=%b exp=111", spk[1][0]); end
  endtask

  initial begin
    bus.conv_done = 1'b0;
    load_zero();
    test_reset();
    test_basic();
    test_zero_frame();
    test_timing();
    test_second_image();
    test_ignored_inputs();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
